// File: rtl/count_req_arbiter_pkg.sv
// Shared definitions for the counter-sharing controllers: FSM state encoding
// and the modulus of the downstream lab counter.
package count_req_arbiter_pkg;

  localparam int LAB_DIV   = 5;
  localparam int LAB_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

endpackage

// File: rtl/count_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: scans from one past the last winner and
// returns the first pending requester as both one-hot and index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_pending,
  input  logic [ID_W-1:0]  i_rrPtr,
  output logic [N_REQ-1:0] o_winnerOh,
  output logic [ID_W-1:0]  o_winnerId,
  output logic             o_anyValid
);

  logic [ID_W-1:0] w_cand;
  logic            w_found;

  always_comb begin
    o_winnerOh = '0;
    o_winnerId = '0;
    w_found    = 1'b0;
    w_cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = ID_W'((int'(i_rrPtr) + k) % N_REQ);
      if (!w_found && i_pending[w_cand]) begin
        w_found    = 1'b1;
        o_winnerId = w_cand;
        o_winnerOh = N_REQ'(1) << w_cand;
      end
    end
    o_anyValid = w_found;
  end

endmodule

// File: rtl/count_req_arbiter.sv
// Shares the mod-DIV pulse-count FSM among N_REQ requesters: captures request
// edges, grants round-robin, issues one w pulse per grant and checks count_in.
module count_req_arbiter
  import count_req_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int DIV    = LAB_DIV,
  parameter int CNT_W  = LAB_CNT_W,
  parameter int DROP_W = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic              count_in,
  output logic              w_out,
  output logic [N_REQ-1:0]  grant,
  output logic              hit_pulse,
  output logic [ID_W-1:0]   hit_id,
  output logic              busy,
  output logic              err,
  output logic [DROP_W-1:0] drop_cnt
);

  state_t            r_state;
  state_t            w_nextState;
  logic [N_REQ-1:0]  r_reqQ;
  logic [N_REQ-1:0]  r_pending;
  logic [CNT_W-1:0]  r_shadow;
  logic [ID_W-1:0]   r_rrPtr;
  logic [ID_W-1:0]   r_grantId;

  logic [N_REQ-1:0]  w_rise;
  logic [N_REQ-1:0]  w_clear;
  logic [N_REQ-1:0]  w_drop;
  logic [N_REQ-1:0]  w_winnerOh;
  logic [ID_W-1:0]   w_winnerId;
  logic              w_anyValid;
  logic              w_doGrant;
  logic              w_atTop;
  logic [CNT_W-1:0]  w_shadowNext;
  logic [DROP_W:0]   w_dropSum;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rrArbiter (
    .i_pending  (r_pending),
    .i_rrPtr    (r_rrPtr),
    .o_winnerOh (w_winnerOh),
    .o_winnerId (w_winnerId),
    .o_anyValid (w_anyValid)
  );

  always_comb begin
    w_nextState = IDLE;
    w_doGrant   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_anyValid) begin
          w_nextState = ISSUE;
          w_doGrant   = 1'b1;
        end
      end
      ISSUE: w_nextState = SETTLE;
      SETTLE: begin
        if (w_anyValid) begin
          w_nextState = ISSUE;
          w_doGrant   = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // A rise on a bit that stays pending is merged and counted as dropped.
  always_comb begin
    w_rise    = req & ~r_reqQ;
    w_clear   = w_doGrant ? w_winnerOh : '0;
    w_drop    = w_rise & r_pending & ~w_clear;
    w_dropSum = {1'b0, drop_cnt};
    for (int i = 0; i < N_REQ; i++) begin
      w_dropSum = w_dropSum + (DROP_W+1)'(w_drop[i]);
    end
  end

  always_comb begin
    w_atTop      = (r_shadow == CNT_W'(DIV - 1));
    w_shadowNext = w_atTop ? '0 : r_shadow + 1'b1;
    busy         = (r_state != IDLE) || (|r_pending);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_reqQ    <= '0;
      r_pending <= '0;
      r_rrPtr   <= ID_W'(N_REQ - 1);
      r_grantId <= '0;
      w_out     <= 1'b0;
      grant     <= '0;
      drop_cnt  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_reqQ    <= req;
      r_pending <= (r_pending & ~w_clear) | w_rise;
      w_out     <= w_doGrant;
      grant     <= w_clear;
      if (w_doGrant) begin
        r_rrPtr   <= w_winnerId;
        r_grantId <= w_winnerId;
      end
      drop_cnt  <= w_dropSum[DROP_W] ? '1 : w_dropSum[DROP_W-1:0];
    end
  end

  // hit_pulse and hit_id are loaded together so the id is valid with the pulse.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      hit_pulse <= 1'b0;
      hit_id    <= '0;
      err       <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      if (r_state == ISSUE) begin
        r_shadow <= w_shadowNext;
        if (w_shadowNext == CNT_W'(DIV - 1)) begin
          hit_pulse <= 1'b1;
          hit_id    <= r_grantId;
        end
      end
      if ((r_state == SETTLE) && (count_in != w_atTop)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_count_req_arbiter.sv
// Bench for count_req_arbiter: a mod-5 counter model stands in for the lab FSM
// and a queue of expected grantees is checked on every w pulse.
module tb_count_req_arbiter;

  logic       clock;
  logic       rst;
  logic [3:0] req;
  logic       count_in;
  logic       w_out;
  logic [3:0] grant;
  logic       hit_pulse;
  logic [1:0] hit_id;
  logic       busy;
  logic       err;
  logic [7:0] drop_cnt;

  int   testsRun    = 0;
  int   testsFailed = 0;
  int   hitsSeen    = 0;
  int   expQ[$];
  int   shadowM     = 0;
  int   expHitId    = 0;
  logic expHit      = 1'b0;
  logic settleNext  = 1'b0;
  logic prevW       = 1'b0;
  logic forceEn     = 1'b0;
  logic [2:0] fsmState;

  count_req_arbiter #(
    .N_REQ  (4),
    .ID_W   (2),
    .DIV    (5),
    .CNT_W  (3),
    .DROP_W (8)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .req       (req),
    .count_in  (count_in),
    .w_out     (w_out),
    .grant     (grant),
    .hit_pulse (hit_pulse),
    .hit_id    (hit_id),
    .busy      (busy),
    .err       (err),
    .drop_cnt  (drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream lab counter: steps on each w pulse, Moore count high in state 4.
  always @(posedge clock or posedge rst) begin
    if (rst) fsmState <= 3'd0;
    else if (w_out) fsmState <= (fsmState == 3'd4) ? 3'd0 : fsmState + 3'd1;
  end

  assign count_in = forceEn ? 1'b1 : (fsmState == 3'd4);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard: every w pulse pops the next expected grantee and predicts
  // whether the following SETTLE cycle carries a hit.
  always @(negedge clock) begin
    if (rst) begin
      expQ.delete();
      shadowM    = 0;
      settleNext = 1'b0;
      prevW      = 1'b0;
    end else begin
      if (settleNext) begin
        checkOutput("hit pulse", {31'd0, hit_pulse}, {31'd0, expHit});
        if (expHit) checkOutput("hit id", {30'd0, hit_id}, expHitId);
        settleNext = 1'b0;
      end else if (hit_pulse) begin
        checkOutput("spurious hit", {31'd0, hit_pulse}, 32'd0);
      end
      if (hit_pulse) hitsSeen++;
      if (w_out) begin
        checkOutput("w repeat", {31'd0, prevW}, 32'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected grant", {28'd0, grant}, 32'd0);
        end else begin
          expHitId = expQ.pop_front();
          checkOutput("grant", {28'd0, grant}, 32'd1 << expHitId);
          shadowM    = (shadowM == 4) ? 0 : shadowM + 1;
          expHit     = (shadowM == 4);
          settleNext = 1'b1;
        end
      end else if (grant != 4'd0) begin
        checkOutput("grant while idle", {28'd0, grant}, 32'd0);
      end
      prevW = w_out;
    end
  end

  task automatic applyReset();
    checkOutput("queue drained", expQ.size(), 32'd0);
    req     = 4'd0;
    forceEn = 1'b0;
    rst     = 1'b1;
    repeat (2) @(negedge clock);
    rst      = 1'b0;
    hitsSeen = 0;
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [1:0] id);
    req[id] = 1'b1;
    expQ.push_back(int'(id));
    @(negedge clock);
    req[id] = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  initial begin
    rst     = 1'b1;
    req     = 4'd0;
    repeat (2) @(negedge clock);
    checkOutput("rst w_out", {31'd0, w_out}, 32'd0);
    checkOutput("rst grant", {28'd0, grant}, 32'd0);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst err", {31'd0, err}, 32'd0);
    checkOutput("rst drop", {24'd0, drop_cnt}, 32'd0);
    checkOutput("rst hit", {29'd0, hit_pulse, hit_id}, 32'd0);
    rst = 1'b0;
    @(negedge clock);

    // Single edge on req[0]: latency and one-cycle pulse.
    req = 4'b0001;
    expQ.push_back(0);
    @(negedge clock);
    checkOutput("t1 busy", {31'd0, busy}, 32'd1);
    checkOutput("t1 w early", {31'd0, w_out}, 32'd0);
    @(negedge clock);
    checkOutput("t1 w issue", {31'd0, w_out}, 32'd1);
    checkOutput("t1 grant", {28'd0, grant}, 32'h1);
    @(negedge clock);
    checkOutput("t1 w settle", {31'd0, w_out}, 32'd0);
    checkOutput("t1 grant settle", {28'd0, grant}, 32'd0);
    @(negedge clock);
    checkOutput("t1 err", {31'd0, err}, 32'd0);
    checkOutput("t1 idle", {31'd0, busy}, 32'd0);
    req = 4'd0;
    repeat (2) @(negedge clock);

    // Five increments from requester 2: one hit on the fourth, wrap on fifth.
    applyReset();
    for (int n = 0; n < 5; n++) applyStimulus(2'd2);
    checkOutput("t2 hits", hitsSeen, 32'd1);
    checkOutput("t2 hit id", {30'd0, hit_id}, 32'd2);
    checkOutput("t2 fsm wrap", {29'd0, fsmState}, 32'd0);
    checkOutput("t2 err", {31'd0, err}, 32'd0);

    // All four rise together: grants 0..3, alternating w.
    applyReset();
    req = 4'b1111;
    for (int n = 0; n < 4; n++) expQ.push_back(n);
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checkOutput("t3 w pattern", {31'd0, w_out}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clock);
    checkOutput("t3 busy drops", {31'd0, busy}, 32'd0);
    checkOutput("t3 hit id", {30'd0, hit_id}, 32'd3);
    checkOutput("t3 err", {31'd0, err}, 32'd0);
    req = 4'd0;
    @(negedge clock);

    // req[1] re-rises while still pending (merged), then again in its ISSUE.
    applyReset();
    req = 4'b0011;
    expQ.push_back(0);
    expQ.push_back(1);
    expQ.push_back(1);
    @(negedge clock);
    req[1] = 1'b0;
    @(negedge clock);
    req[1] = 1'b1;
    @(negedge clock);
    req[1] = 1'b0;
    @(negedge clock);
    checkOutput("t4 issue 1", {28'd0, grant}, 32'h2);
    req[1] = 1'b1;
    repeat (6) @(negedge clock);
    checkOutput("t4 drop", {24'd0, drop_cnt}, 32'd1);
    checkOutput("t4 idle", {31'd0, busy}, 32'd0);
    req = 4'd0;
    @(negedge clock);

    // Forced count mismatch makes err sticky until reset.
    applyReset();
    applyStimulus(2'd0);
    checkOutput("t5 err clean", {31'd0, err}, 32'd0);
    forceEn = 1'b1;
    applyStimulus(2'd0);
    forceEn = 1'b0;
    checkOutput("t5 err set", {31'd0, err}, 32'd1);
    applyStimulus(2'd3);
    checkOutput("t5 err sticky", {31'd0, err}, 32'd1);
    applyReset();
    checkOutput("t5 err cleared", {31'd0, err}, 32'd0);

    // Reset during ISSUE discards the pulse and the other pending request.
    req = 4'b0101;
    expQ.push_back(0);
    repeat (2) @(negedge clock);
    checkOutput("t6 in issue", {31'd0, w_out}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6 w dropped", {31'd0, w_out}, 32'd0);
    checkOutput("t6 grant dropped", {28'd0, grant}, 32'd0);
    checkOutput("t6 pending lost", {31'd0, busy}, 32'd0);
    req = 4'd0;
    repeat (2) @(negedge clock);
    rst = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("t6 no residual w", {31'd0, w_out}, 32'd0);
    checkOutput("t6 no residual grant", {28'd0, grant}, 32'd0);
    checkOutput("t6 busy", {31'd0, busy}, 32'd0);
    checkOutput("t6 queue", expQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/count_req_arbiter.md
Name: count_req_arbiter

Overview:
Shares one mod-5 pulse-count FSM (the lab counter: `w`-driven, with Moore `count` high in state 4) among N_REQ independent requesters. Rising edges on each request line are captured as pending increments. A round-robin arbiter grants one pending requester at a time and drives exactly one single-cycle `w` pulse per grant. The block keeps a shadow count and checks the FSM's Moore `count` output against it. It sits between the switch/button inputs and the counting FSM on the lab board.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index; ceil(log2(N_REQ))
DIV, 5, count modulus of the downstream FSM; Moore count expected high when shadow == DIV-1
CNT_W, 3, shadow counter width; ceil(log2(DIV))
DROP_W, 8, width of the saturating dropped-request counter

Ports:
clock  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  N_REQ  level request lines; each rising edge is one increment request
count_in  in  1  Moore count output of the downstream FSM
w_out  out  1  w input to the downstream FSM; registered
grant  out  N_REQ  one-hot, registered; equals the grantee while w_out=1, else 0
hit_pulse  out  1  one-cycle pulse when a granted increment brings the shadow to DIV-1
hit_id  out  ID_W  index of the requester whose increment caused the last hit; holds its value
busy  out  1  high when state != IDLE or any pending bit is set
err  out  1  sticky; set when count_in mismatches the shadow expectation
drop_cnt  out  DROP_W  saturating count of requests merged into an already-pending bit

Behaviour:
- Reset (rst=1, async): state=IDLE, req_q=0, pending=0, shadow=0, rr_ptr=N_REQ-1, w_out=0, grant=0, hit_pulse=0, hit_id=0, err=0, drop_cnt=0.
  - rst mid-ISSUE drops w_out immediately and loses all pending bits; no partial pulse is retried.
- Edge capture:
  - rise_i = req[i] & ~req_q[i], where req_q is registered each clock.
  - On rise_i, pending[i] <= 1.
  - If pending[i] is already 1 and not being cleared this cycle, drop_cnt increments, saturating at all-ones.
- Arbitration:
  - Search starts at rr_ptr+1 and wraps modulo N_REQ; the first set pending bit wins.
  - rr_ptr <= winner on grant.
  - Set and clear of the same pending bit in one cycle: set wins, so a new edge during a grant re-pends.
- State machine (states IDLE, ISSUE, SETTLE):
  - IDLE: w_out=0. If any pending bit is set, next state is ISSUE; register grant=winner and clear pending[winner].
  - ISSUE: exactly one cycle, w_out=1, grant one-hot. shadow <= (shadow==DIV-1) ? 0 : shadow+1. Next state SETTLE.
  - SETTLE: w_out=0, grant=0. The downstream FSM has taken the step and its Moore output is valid.
    - If shadow==DIV-1: hit_pulse=1 this cycle and hit_id <= granted id.
    - Check count_in == (shadow==DIV-1); on mismatch, err <= 1.
    - If any pending bit is set, go directly to ISSUE with a new grant; otherwise go to IDLE.
- Latency:
  - req rises before edge k → pending set at edge k → ISSUE (w_out=1) from edge k+1 → SETTLE from edge k+2.
  - hit_pulse and the check occur in cycle k+2..k+3.
- Throughput: back-to-back grants give 1 increment per 2 cycles; w_out is never high for 2 consecutive cycles.
- Shadow wrap: after DIV-1 the shadow wraps to 0. This matches the FSM's state-4 → state-0 transition.
- busy is combinational from state and pending.
- All other outputs are registered.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, SETTLE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - DIV and CNT_W constants, shared with the counting FSM.
- One sub-module: rr_arbiter.
  - Inputs: pending, rr_ptr. Outputs: one-hot winner, winner id, any_valid.
  - Purely combinational; it is reused by the other shared-resource controllers.

Test Plan:
- Reset then a single edge on req[0] → w_out=1 for exactly one cycle at edge k+1, grant=4'b0001. In SETTLE count_in=0 is expected, err stays 0, shadow=1.
- Five single edges on req[2] spaced 6 cycles apart → hit_pulse exactly once, on the 4th increment, with hit_id=2. After the 5th increment shadow=0 and the FSM count returns to 0.
- All four req rise in the same cycle → grants in order 0,1,2,3. w_out pattern is 1,0,1,0,1,0,1,0 and busy drops after the last SETTLE.
- req[1] toggles twice before its first grant → one grant only, drop_cnt=1. An edge arriving during req[1]'s ISSUE cycle → a second grant follows.
- Force count_in=1 while shadow=2 in SETTLE → err=1 and it stays 1 across further traffic until rst.
- Assert rst in the ISSUE cycle → w_out, grant and pending all go to 0 immediately. After release, no residual grant and busy=0.
